// File: rtl/rr_mux_arbiter.sv
// Four-source round-robin arbiter driving a shared 4:1 data select into a
// single valid/ready output register, with per-source burst locking.
module rr_mux_arbiter #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [3:0]   lock,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] in_c,
  input  logic [N-1:0] in_d,
  output logic [3:0]   gnt,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  output logic [1:0]   out_src,
  input  logic         out_ready,
  output logic         locked
);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     ptr_q, ptr_d;
  logic [1:0]     owner_q, owner_d;
  logic           out_valid_q, out_valid_d;
  logic [N-1:0]   out_data_q, out_data_d;
  logic [1:0]     out_src_q, out_src_d;

  logic           cap_ok;
  logic           rr_any;
  logic [1:0]     rr_idx;
  logic [1:0]     scan_idx;
  logic [1:0]     win_idx;
  logic           win_req;
  logic [N-1:0]   sel_data;
  logic           capture;
  logic [3:0]     gnt_raw;

  assign cap_ok = !out_valid_q || out_ready;

  // Winner selection depends only on state and req, never on the datapath,
  // so it is kept apart from the next-state logic.
  always_comb begin
    rr_any   = 1'b0;
    rr_idx   = ptr_q;
    scan_idx = ptr_q;
    for (int unsigned i = 0; i < 4; i++) begin
      scan_idx = ptr_q + 2'(i);
      if (!rr_any && req[scan_idx]) begin
        rr_any = 1'b1;
        rr_idx = scan_idx;
      end
    end
    if (state_q == S_LOCKED) begin
      win_idx = owner_q;
      win_req = req[owner_q];
    end else begin
      win_idx = rr_idx;
      win_req = rr_any;
    end
  end

  always_comb begin
    sel_data = in_a;
    unique case (win_idx)
      2'd0: sel_data = in_a;
      2'd1: sel_data = in_b;
      2'd2: sel_data = in_c;
      2'd3: sel_data = in_d;
      default: sel_data = in_a;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    capture     = 1'b0;
    gnt_raw     = '0;

    unique case (state_q)
      S_IDLE: begin
        if (win_req && cap_ok) begin
          capture = 1'b1;
          ptr_d   = win_idx + 2'd1;
          if (lock[win_idx]) begin
            state_d = S_LOCKED;
            owner_d = win_idx;
          end
        end
      end
      S_LOCKED: begin
        // Dropping the request ends the burst even while the output is stalled.
        if (!win_req) begin
          state_d = S_IDLE;
          ptr_d   = owner_q + 2'd1;
        end else if (cap_ok) begin
          capture = 1'b1;
          if (!lock[owner_q]) begin
            state_d = S_IDLE;
            ptr_d   = owner_q + 2'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (capture) begin
      gnt_raw[win_idx] = 1'b1;
      out_valid_d      = 1'b1;
      out_data_d       = sel_data;
      out_src_d        = win_idx;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign gnt       = rst ? '0 : gnt_raw;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign locked    = (state_q == S_LOCKED);

  a_gnt_onehot0: assert property (@(posedge clk) $onehot0(gnt));
  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_src)));

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: the driver pushes expected words on each
// expected grant, and a monitor pops and compares on every output handshake.
module tb_rr_mux_arbiter;

  localparam int N = 16;

  typedef struct {
    logic [1:0]   src;
    logic [N-1:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req = 4'b1111;
  logic [3:0]   lock = 4'b0000;
  logic [N-1:0] in_a = 16'h1111;
  logic [N-1:0] in_b = 16'h2222;
  logic [N-1:0] in_c = 16'h3333;
  logic [N-1:0] in_d = 16'h4444;
  logic [3:0]   gnt;
  logic         out_valid;
  logic [N-1:0] out_data;
  logic [1:0]   out_src;
  logic         out_ready = 1'b1;
  logic         locked;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [N-1:0] src_val [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

  rr_mux_arbiter #(.N(N)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
    .gnt(gnt), .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs shortly after the edge, check the combinational grant,
  // and queue the word the grant should deliver.
  task automatic step(input logic [3:0] r, input logic [3:0] l, input logic rdy,
                      input logic [3:0] eg, input string name);
    exp_t e;
    @(posedge clk); #2;
    req = r; lock = l; out_ready = rdy;
    #1;
    chk({name, "_gnt"}, 32'(gnt), 32'(eg));
    if (eg != 4'b0000) begin
      case (eg)
        4'b0001: e.src = 2'd0;
        4'b0010: e.src = 2'd1;
        4'b0100: e.src = 2'd2;
        default: e.src = 2'd3;
      endcase
      e.data = src_val[e.src];
      sb.push_back(e);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: unexpected word src=%0d data=0x%0h", out_src, out_data);
        end else begin
          e = sb.pop_front();
          chk("mon_src", 32'(out_src), 32'(e.src));
          chk("mon_data", 32'(out_data), 32'(e.data));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin : driver
    // Reset with all requests up: no grant may leak out.
    repeat (2) begin
      @(posedge clk); #3;
      chk("rst_gnt", 32'(gnt), 32'h0);
    end
    @(posedge clk); #2;
    rst = 1'b0; req = 4'b0000;
    #1;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_src", 32'(out_src), 32'h0);
    chk("rst_locked", 32'(locked), 32'h0);
    chk("rst_gnt_idle", 32'(gnt), 32'h0);

    // Full round robin, two laps; leaves ptr at A.
    for (int lap = 0; lap < 2; lap++) begin
      step(4'b1111, 4'b0000, 1'b1, 4'b0001, "rr_a");
      step(4'b1111, 4'b0000, 1'b1, 4'b0010, "rr_b");
      step(4'b1111, 4'b0000, 1'b1, 4'b0100, "rr_c");
      step(4'b1111, 4'b0000, 1'b1, 4'b1000, "rr_d");
    end
    step(4'b0000, 4'b0000, 1'b1, 4'b0000, "rr_drain");

    // Back-pressure: A captured, held 5 cycles, then C wins.
    step(4'b0101, 4'b0000, 1'b1, 4'b0001, "bp_first");
    for (int k = 0; k < 5; k++) begin
      step(4'b0101, 4'b0000, 1'b0, 4'b0000, "bp_stall");
      chk("bp_valid", 32'(out_valid), 32'h1);
      chk("bp_hold_data", 32'(out_data), 32'h1111);
    end
    step(4'b0101, 4'b0000, 1'b1, 4'b0100, "bp_next_c");
    step(4'b0000, 4'b0000, 1'b1, 4'b0000, "bp_drain");

    // Lock burst on B: three locked grants plus the releasing one, then C.
    step(4'b0001, 4'b0000, 1'b1, 4'b0001, "lk_pre_a");
    step(4'b1111, 4'b0010, 1'b1, 4'b0010, "lk_b1");
    chk("lk_locked_pre", 32'(locked), 32'h0);
    step(4'b1111, 4'b0010, 1'b1, 4'b0010, "lk_b2");
    chk("lk_locked_b2", 32'(locked), 32'h1);
    step(4'b1111, 4'b0010, 1'b1, 4'b0010, "lk_b3");
    chk("lk_locked_b3", 32'(locked), 32'h1);
    step(4'b1111, 4'b0000, 1'b1, 4'b0010, "lk_b4");
    chk("lk_locked_b4", 32'(locked), 32'h1);
    step(4'b1111, 4'b0000, 1'b1, 4'b0100, "lk_next_c");
    chk("lk_unlocked", 32'(locked), 32'h0);
    step(4'b0000, 4'b0000, 1'b1, 4'b0000, "lk_drain");

    // Lock on D released by dropping its request.
    step(4'b1000, 4'b1000, 1'b1, 4'b1000, "drop_d");
    step(4'b0111, 4'b0000, 1'b1, 4'b0000, "drop_gap");
    chk("drop_locked_gap", 32'(locked), 32'h1);
    step(4'b0111, 4'b0000, 1'b1, 4'b0001, "drop_next_a");
    chk("drop_unlocked", 32'(locked), 32'h0);
    step(4'b0000, 4'b0000, 1'b1, 4'b0000, "drop_drain");

    // Drain and capture in the same cycle.
    step(4'b0010, 4'b0000, 1'b1, 4'b0010, "dc_b");
    chk("dc_valid_pre", 32'(out_valid), 32'h0);
    step(4'b0100, 4'b0000, 1'b1, 4'b0100, "dc_c");
    chk("dc_valid_b", 32'(out_valid), 32'h1);
    step(4'b0000, 4'b0000, 1'b0, 4'b0000, "dc_hold");
    chk("dc_valid_c", 32'(out_valid), 32'h1);
    chk("dc_data_c", 32'(out_data), 32'h3333);
    chk("dc_src_c", 32'(out_src), 32'h2);

    // Reset while holding a word and locked.
    step(4'b1000, 4'b1000, 1'b1, 4'b1000, "mr_d");
    @(posedge clk); #2;
    chk("mr_pre_valid", 32'(out_valid), 32'h1);
    chk("mr_pre_locked", 32'(locked), 32'h1);
    rst = 1'b1; req = 4'b1111; lock = 4'b0000; out_ready = 1'b0;
    sb.delete();
    #1;
    chk("mr_gnt", 32'(gnt), 32'h0);
    @(posedge clk); #2;
    rst = 1'b0; req = 4'b0000; out_ready = 1'b1;
    #1;
    chk("mr_valid", 32'(out_valid), 32'h0);
    chk("mr_locked", 32'(locked), 32'h0);
    chk("mr_data", 32'(out_data), 32'h0);
    chk("mr_gnt_after", 32'(gnt), 32'h0);
    step(4'b1111, 4'b0000, 1'b1, 4'b0001, "mr_first_a");
    step(4'b0000, 4'b0000, 1'b1, 4'b0000, "mr_drain");

    for (int w = 0; w < 20 && sb.size() != 0; w++) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Four-requester round-robin arbiter that shares one N-bit 4:1 select datapath between sources A–D.
- Drives the select internally, registers the winning word into a single output stage, and hands it off with a valid/ready handshake.
- Supports locked bursts, in which a requester keeps ownership across consecutive transfers.
- Sits between ALU/register-file producers and a single shared consumer such as a writeback bus.

Parameters:
- N, 16, data width of each source and of out_data.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request per source; bit0=A, bit1=B, bit2=C, bit3=D.
- lock  input  4  per-source burst-lock request, sampled only when that source is granted.
- in_a  input  N  source A data.
- in_b  input  N  source B data.
- in_c  input  N  source C data.
- in_d  input  N  source D data.
- gnt  output  4  one-hot, combinational; high exactly in the cycle the source's word is captured (source may drop or advance data next cycle).
- out_valid  output  1  output register holds an unconsumed word.
- out_data  output  N  registered captured word.
- out_src  output  2  index of the source that produced out_data.
- out_ready  input  1  consumer accepts out_data when out_valid && out_ready.
- locked  output  1  arbiter is in LOCKED state.

Behaviour:
- The design has one clock and one reset: clk, with synchronous active-high rst. No asynchronous logic.
- On rst:
  - out_valid=0, out_data=0, out_src=0, locked=0.
  - Round-robin pointer ptr=0; owner=0; state=IDLE.
  - gnt=0 during the reset cycle.
- Reset mid-transfer discards any held word; there is no partial handshake.
- Capture enable: cap_ok = !out_valid || out_ready. The output stage is a pipeline register, so full throughput is one word per cycle.
- State IDLE:
  - Winner = first set bit of req scanning ptr, ptr+1, … mod 4.
  - If any req and cap_ok: gnt[winner]=1; out_data<=selected input; out_src<=winner; out_valid<=1; ptr<=winner+1 mod 4.
  - If lock[winner]=1 at capture: state<=LOCKED, owner<=winner.
- State LOCKED:
  - Only owner is eligible; other reqs are ignored and ptr is frozen.
  - If req[owner] and cap_ok: capture as above.
    - lock[owner]=0 at that capture: state<=IDLE and ptr<=owner+1.
    - Otherwise remain LOCKED.
  - If req[owner]=0: state<=IDLE next cycle with no capture; ptr<=owner+1.
- Output handshake:
  - If out_valid && out_ready and there is no capture this cycle, out_valid<=0.
  - A simultaneous drain and capture keeps out_valid=1 with new data.
  - out_data and out_src are stable while out_valid && !out_ready.
- Latency: a word granted in cycle t appears on out_data with out_valid=1 in cycle t+1.
- No req, or cap_ok=0: gnt=0 and state/ptr unchanged (a stall never advances fairness).
- locked = (state==LOCKED), registered.
- The datapath select uses the 2-bit winner index with encoding 00=A, 01=B, 10=C, 11=D.

Test Plan:
- Reset, then all four reqs held and out_ready=1 → gnt sequence A,B,C,D,A… one per cycle; out_src 0,1,2,3,0 one cycle later; out_data matches in_a=0x1111, in_b=0x2222, in_c=0x3333, in_d=0x4444.
- Back-pressure:
  - Setup: req=0101, out_ready=0 after the first capture.
  - Expected: gnt=0001 once, then gnt=0; out_valid=1 with out_data=0x1111 held stable for 5 cycles.
  - Then out_ready=1: next capture is C (gnt=0100), not A.
- Lock burst:
  - Setup: req=1111, lock[1]=1 for 3 grants to B, then lock[1]=0.
  - Expected: gnt=0010 for 4 consecutive captures; locked=1 during the burst, 0 after; next grant is C.
- Lock release by request drop:
  - Setup: LOCKED on D, then req[3]=0.
  - Expected: one cycle with no grant; IDLE; next winner scans from A.
- Drain and capture same cycle: out_valid=1, out_ready=1, req=0100 → out_valid stays 1, out_data updates to 0x3333, gnt=0100.
- Reset mid-operation: assert rst while out_valid=1 and locked=1 → next cycle out_valid=0, locked=0, out_data=0, gnt=0; first post-reset grant with req=1111 is A.
